config_stream_loader: RTL and testbench

- Single-clock controller that loads a logic-tile config shift chain (one or more tiles daisy-chained) from a word-wide host stream.
- Clears the chain, then serializes words into it at one bit per cycle with no bubbles under sustained input.
- Counts exactly the chain length, then releases the fabric enable.
- Sits between the bitstream source and the config_in / config_enable / config_nreset pins of the tile array.

---
 rtl/config_loader_pkg.sv | 28 ++
 rtl/config_word_serializer.sv | 83 ++++++++
 rtl/config_stream_loader.sv | 121 ++++++++++++
 tb/tb_config_stream_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and geometry helpers for the config stream loader.
//   state_t         : loader FSM states
//   total_bits      : N = bits per tile * tiles on the chain
//   words_total     : host words needed to cover N bits
//   last_word_bits  : bits actually shifted from the final word
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int total_bits(input int chain_length, input int tile_count);
    return chain_length * tile_count;
  endfunction

  function automatic int words_total(input int n, input int word_width);
    return (n + word_width - 1) / word_width;
  endfunction

  // A partial final word only contributes its low (n mod width) bits.
  function automatic int last_word_bits(input int n, input int word_width);
    return ((n % word_width) == 0) ? word_width : (n % word_width);
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Word holding register and bit serializer for the config loader.
// Ports:
//   clock, nreset   : clock, async active-low reset
//   active_i        : loader is in LOAD and not aborting this cycle
//   allow_ready_i   : next cycle is LOAD and words remain to be accepted
//   word_bits_i     : bits to use from a word accepted this cycle
//   word_data_i/word_valid_i : host word stream
//   accept_o        : handshake completes this cycle
//   word_ready_o    : registered ready to the host
//   bit_o, bit_en_o : registered serial bit and shift enable to the chain
module config_word_serializer #(
  parameter  int WORD_WIDTH = 8,
  localparam int LW         = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  active_i,
  input  logic                  allow_ready_i,
  input  logic [LW-1:0]         word_bits_i,
  input  logic [WORD_WIDTH-1:0] word_data_i,
  input  logic                  word_valid_i,
  output logic                  accept_o,
  output logic                  word_ready_o,
  output logic                  bit_o,
  output logic                  bit_en_o
);

  // hold_q[0] is the bit currently on bit_o; left_q counts that bit plus
  // the ones still waiting, so left_q==0 means the register is empty.
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic [LW-1:0]         left_q, left_d;
  logic                  ready_q, ready_d;
  logic                  dout_q, dout_d;
  logic                  en_q, en_d;

  assign accept_o = active_i & word_valid_i & ready_q;

  always_comb begin
    hold_d = hold_q;
    left_d = left_q;
    dout_d = dout_q;
    en_d   = 1'b0;
    if (!active_i) begin
      left_d = '0;
    end else if (accept_o) begin
      hold_d = word_data_i;
      left_d = word_bits_i;
      dout_d = word_data_i[0];
      en_d   = 1'b1;
    end else if (left_q > LW'(1)) begin
      hold_d = hold_q >> 1;
      left_d = left_q - LW'(1);
      dout_d = hold_q[1];
      en_d   = 1'b1;
    end else begin
      // Word exhausted and nothing new: starve, keep the data pin steady.
      left_d = '0;
    end
    // Asking for the next word while the last bit is out keeps 1 bit/cycle.
    ready_d = allow_ready_i & (left_d <= LW'(1));
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hold_q  <= '0;
      left_q  <= '0;
      ready_q <= 1'b0;
      dout_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      left_q  <= left_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
    end
  end

  assign word_ready_o = ready_q;
  assign bit_o        = dout_q;
  assign bit_en_o     = en_q;

endmodule

// File: rtl/config_stream_loader.sv
// Loads a daisy-chained tile config shift chain from a word-wide stream:
// clears the chain, shifts exactly N bits LSB-first, then enables the fabric.
// Ports:
//   clock, nreset        : clock (also the chain's config clock), async reset
//   start, abort         : begin a load (IDLE/DONE only) / return to IDLE
//   word_data/valid/ready: host word stream handshake
//   config_data_out      : serial bit to the first tile's config_in
//   config_enable        : chain shift enable
//   config_nreset        : chain clear, active low
//   fabric_enable        : user logic enable after a complete load
//   busy, done           : status (CLEAR/LOAD, DONE)
module config_stream_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 524,
  parameter int TILE_COUNT   = 1,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  fabric_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = total_bits(CHAIN_LENGTH, TILE_COUNT);
  localparam int WORDS = words_total(N, WORD_WIDTH);
  localparam int LAST  = last_word_bits(N, WORD_WIDTH);
  localparam int BCW   = $clog2(N + 1);
  localparam int WCW   = $clog2(WORDS + 1);
  localparam int CCW   = $clog2(CLEAR_CYCLES + 1);
  localparam int LW    = $clog2(WORD_WIDTH + 1);

  state_t         state_q, state_d;
  logic [BCW-1:0] bits_q, bits_d;
  logic [WCW-1:0] words_q, words_d;
  logic [CCW-1:0] clr_q, clr_d;
  logic           nres_q, fab_q, busy_q, done_q;
  logic           accept, allow_ready, active;
  logic [LW-1:0]  word_bits;

  // config_enable is high exactly while a counted bit sits on the pin, so the
  // N-th bit is on the pin when the count of earlier bits is N-1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   if (clr_q == CCW'(CLEAR_CYCLES - 1)) state_d = LOAD;
      LOAD:    if (config_enable && bits_q == BCW'(N - 1)) state_d = DONE;
      DONE:    if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    clr_d = (state_q == CLEAR) ? clr_q + CCW'(1) : '0;
    if (state_q == CLEAR) begin
      bits_d  = '0;
      words_d = WCW'(WORDS);
    end else begin
      bits_d  = bits_q + BCW'(config_enable);
      words_d = words_q - WCW'(accept);
    end
  end

  assign active      = (state_q == LOAD) && !abort;
  assign allow_ready = (state_d == LOAD) && (words_d != '0);
  assign word_bits   = (words_q == WCW'(1)) ? LW'(LAST) : LW'(WORD_WIDTH);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      bits_q  <= '0;
      words_q <= '0;
      clr_q   <= '0;
      nres_q  <= 1'b1;
      fab_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      words_q <= words_d;
      clr_q   <= clr_d;
      nres_q  <= (state_d != CLEAR);
      fab_q   <= (state_d == DONE);
      busy_q  <= (state_d == CLEAR) || (state_d == LOAD);
      done_q  <= (state_d == DONE);
    end
  end

  config_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clock         (clock),
    .nreset        (nreset),
    .active_i      (active),
    .allow_ready_i (allow_ready),
    .word_bits_i   (word_bits),
    .word_data_i   (word_data),
    .word_valid_i  (word_valid),
    .accept_o      (accept),
    .word_ready_o  (word_ready),
    .bit_o         (config_data_out),
    .bit_en_o      (config_enable)
  );

  assign config_nreset = nres_q;
  assign fabric_enable = fab_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_config_stream_loader.sv
module tb_config_stream_loader;
  localparam int CLR = 2;

  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  logic [1:0]      start, abort, word_valid;
  logic [1:0][7:0] word_data;
  wire  [1:0]      word_ready, config_data_out, config_enable, config_nreset;
  wire  [1:0]      fabric_enable, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: 16-bit chain. Instance 1: 2 tiles x 6 bits = 12-bit chain.
  config_stream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(16), .TILE_COUNT(1), .CLEAR_CYCLES(CLR)) u_dut16 (
    .clock(clock), .nreset(nreset), .start(start[0]), .abort(abort[0]),
    .word_data(word_data[0]), .word_valid(word_valid[0]), .word_ready(word_ready[0]),
    .config_data_out(config_data_out[0]), .config_enable(config_enable[0]),
    .config_nreset(config_nreset[0]), .fabric_enable(fabric_enable[0]),
    .busy(busy[0]), .done(done[0]));

  config_stream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(6), .TILE_COUNT(2), .CLEAR_CYCLES(CLR)) u_dut12 (
    .clock(clock), .nreset(nreset), .start(start[1]), .abort(abort[1]),
    .word_data(word_data[1]), .word_valid(word_valid[1]), .word_ready(word_ready[1]),
    .config_data_out(config_data_out[1]), .config_enable(config_enable[1]),
    .config_nreset(config_nreset[1]), .fabric_enable(fabric_enable[1]),
    .busy(busy[1]), .done(done[1]));

  // Words the source will offer for the next load.
  logic [7:0] src_words[$];

  // Results of the last run_load.
  int         r_nres_first, r_nres_cnt, r_first_en, r_last_en, r_en_cnt, r_done_cyc;
  int         r_tail_mis, r_busy_mis, r_extra_rdy;
  logic       r_fab_c1;
  logic [15:0] r_chain;
  logic [6:0] r_sn;   // {ready, dout, en, nres, fab, busy, done}

  function automatic int chain_bits(input int idx);
    return (idx == 0) ? 16 : 12;
  endfunction

  // Reference: stream bit i (LSB-first across words) ends at chain position i;
  // bits beyond n are never shifted.
  function automatic logic [15:0] model_chain(input int n);
    logic [15:0] c;
    logic [7:0]  w;
    c = '0;
    for (int i = 0; i < n; i++) begin
      w    = src_words[i / 8];
      c[i] = w[i % 8];
    end
    return c;
  endfunction

  // Drives one load on instance idx starting at cycle 0 (start high in cycle 0).
  // gap: cycles the source withholds each word after the first while ready.
  // restart_cyc: cycle to pulse start again. stop_kind 1/2: abort / nreset
  // once stop_bits bits have appeared.
  task automatic run_load(input int idx, input int gap, input int restart_cyc,
                          input int stop_bits, input int stop_kind);
    int wi, skip, cyc, n;
    bit fin, stopping;
    n = chain_bits(idx);
    r_nres_first = -1; r_nres_cnt = 0; r_first_en = -1; r_last_en = -1; r_en_cnt = 0;
    r_done_cyc = -1; r_tail_mis = 0; r_busy_mis = 0; r_extra_rdy = 0; r_fab_c1 = 1'b1;
    r_chain = '0; r_sn = '0;
    wi = 0; skip = 0; cyc = 0; fin = 0; stopping = 0;
    @(negedge clock);
    while (!fin) begin
      if (cyc >= 1) begin
        if (stopping) begin
          r_sn = {word_ready[idx], config_data_out[idx], config_enable[idx], config_nreset[idx],
                  fabric_enable[idx], busy[idx], done[idx]};
          fin = 1;
        end else begin
          if (!config_nreset[idx]) begin
            r_nres_cnt++;
            if (r_nres_first < 0) r_nres_first = cyc;
          end
          if (config_enable[idx]) begin
            r_en_cnt++;
            if (r_first_en < 0) r_first_en = cyc;
            r_last_en = cyc;
            r_chain = (r_chain >> 1) | (16'(config_data_out[idx]) << (n - 1));
          end
          if (cyc == 1) r_fab_c1 = fabric_enable[idx];
          if (done[idx] && r_done_cyc < 0) r_done_cyc = cyc;
          if (fabric_enable[idx] !== (r_done_cyc >= 0)) r_tail_mis++;
          if (r_done_cyc >= 0 && done[idx] !== 1'b1) r_tail_mis++;
          if (busy[idx] !== (r_done_cyc < 0)) r_busy_mis++;
          if (r_done_cyc >= 0 && cyc > r_done_cyc) fin = 1;
          if (cyc > 400) fin = 1;
        end
      end
      if (!fin) begin
        start[idx] = (cyc == 0 || cyc == restart_cyc);
        abort[idx] = 1'b0;
        if (stop_kind == 1 && r_en_cnt == stop_bits && !stopping) begin
          abort[idx] = 1'b1;
          stopping   = 1;
        end
        if (word_ready[idx]) begin
          if (wi >= src_words.size()) begin
            r_extra_rdy++;
            word_valid[idx] = 1'b1; word_data[idx] = 8'($urandom);
          end else if (skip > 0) begin
            word_valid[idx] = 1'b0; skip--;
          end else begin
            word_valid[idx] = 1'b1; word_data[idx] = src_words[wi];
            wi++; skip = gap;
          end
        end else begin
          // Offer junk while not ready: it must never be consumed.
          word_valid[idx] = 1'b1; word_data[idx] = 8'($urandom);
        end
        if (stop_kind == 2 && r_en_cnt == stop_bits) begin
          #2 nreset = 1'b0;
          #1 r_sn = {word_ready[idx], config_data_out[idx], config_enable[idx], config_nreset[idx],
                     fabric_enable[idx], busy[idx], done[idx]};
          fin = 1;
        end
        cyc++;
        if (!fin) @(negedge clock);
      end
    end
    start[idx] = 1'b0;
    abort[idx] = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    nreset = 1'b0; start = '0; abort = '0; word_valid = '1; word_data = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      got = {word_ready[i], config_data_out[i], config_enable[i], config_nreset[i],
             fabric_enable[i], busy[i], done[i]};
      n_checks++;
      if (got !== 7'b0001000) begin
        n_fail++; $display("FAIL reset_values[%0d]: got %b want 0001000", i, got);
      end
    end
    nreset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (word_ready !== 2'b00 || busy !== 2'b00) begin
      n_fail++; $display("FAIL idle_ignores_valid: ready %b busy %b want 00 00", word_ready, busy);
    end
  endtask

  task automatic test_basic;
    src_words = {8'hA5, 8'h3C};
    run_load(0, 0, -1, 0, 0);
    n_checks++;
    if (r_nres_first !== 1 || r_nres_cnt !== CLR) begin
      n_fail++; $display("FAIL basic_clear: first %0d cnt %0d want 1 %0d", r_nres_first, r_nres_cnt, CLR);
    end
    n_checks++;
    if (r_first_en !== CLR + 2 || r_last_en !== CLR + 17 || r_en_cnt !== 16) begin
      n_fail++; $display("FAIL basic_enable: first %0d last %0d cnt %0d want %0d %0d 16",
                         r_first_en, r_last_en, r_en_cnt, CLR + 2, CLR + 17);
    end
    n_checks++;
    if (r_chain !== 16'h3CA5) begin
      n_fail++; $display("FAIL basic_chain: got %h want 3ca5", r_chain);
    end
    n_checks++;
    if (r_done_cyc !== CLR + 18) begin
      n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", r_done_cyc, CLR + 18);
    end
    n_checks++;
    if (r_tail_mis !== 0 || r_busy_mis !== 0 || r_extra_rdy !== 0) begin
      n_fail++; $display("FAIL basic_status: fab/done %0d busy %0d extra_ready %0d want 0 0 0",
                         r_tail_mis, r_busy_mis, r_extra_rdy);
    end
  endtask

  task automatic test_partial;
    src_words = {8'hFF, 8'h0F};
    run_load(1, 0, -1, 0, 0);
    n_checks++;
    if (r_en_cnt !== 12 || r_chain[11:0] !== 12'hFFF) begin
      n_fail++; $display("FAIL partial_word: cnt %0d chain %h want 12 fff", r_en_cnt, r_chain[11:0]);
    end
    n_checks++;
    if (r_chain[11:8] !== 4'hF || r_done_cyc !== CLR + 14) begin
      n_fail++; $display("FAIL partial_tail: last4 %h done %0d want f %0d", r_chain[11:8], r_done_cyc, CLR + 14);
    end
  endtask

  task automatic test_gap;
    src_words = {8'hA5, 8'h3C};
    run_load(0, 3, -1, 0, 0);
    n_checks++;
    if (r_en_cnt !== 16 || r_chain !== 16'h3CA5) begin
      n_fail++; $display("FAIL gap_chain: cnt %0d chain %h want 16 3ca5", r_en_cnt, r_chain);
    end
    n_checks++;
    if (r_last_en - r_first_en + 1 - r_en_cnt !== 3 || r_done_cyc !== CLR + 21) begin
      n_fail++; $display("FAIL gap_timing: bubbles %0d done %0d want 3 %0d",
                         r_last_en - r_first_en + 1 - r_en_cnt, r_done_cyc, CLR + 21);
    end
  endtask

  task automatic test_random;
    int idx, gap, n;
    for (int k = 0; k < 8; k++) begin
      idx = k % 2;
      n   = chain_bits(idx);
      gap = int'($urandom_range(0, 3));
      src_words = {8'($urandom), 8'($urandom)};
      run_load(idx, gap, -1, 0, 0);
      n_checks++;
      if (r_en_cnt !== n || r_chain !== model_chain(n) || r_done_cyc !== CLR + 2 + n + gap) begin
        n_fail++; $display("FAIL random[%0d]: cnt %0d chain %h done %0d want %0d %h %0d",
                           k, r_en_cnt, r_chain, r_done_cyc, n, model_chain(n), CLR + 2 + n + gap);
      end
    end
  endtask

  task automatic test_abort;
    src_words = {8'hA5, 8'h3C};
    run_load(0, 0, -1, 5, 1);
    n_checks++;
    if ({r_sn[6], r_sn[4:0]} !== 6'b001000 || r_en_cnt !== 5) begin
      n_fail++; $display("FAIL abort_state: got %b bits %0d want 001000 5", {r_sn[6], r_sn[4:0]}, r_en_cnt);
    end
    run_load(0, 0, -1, 0, 0);
    n_checks++;
    if (r_nres_cnt !== CLR || r_chain !== 16'h3CA5 || r_done_cyc !== CLR + 18) begin
      n_fail++; $display("FAIL abort_reload: clear %0d chain %h done %0d want %0d 3ca5 %0d",
                         r_nres_cnt, r_chain, r_done_cyc, CLR, CLR + 18);
    end
    // From DONE: abort and start together, abort must win.
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0; abort[0] = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy[0], done[0], fabric_enable[0], config_nreset[0], config_enable[0]} !== 5'b00010) begin
      n_fail++; $display("FAIL abort_beats_start: got %b want 00010",
                         {busy[0], done[0], fabric_enable[0], config_nreset[0], config_enable[0]});
    end
  endtask

  task automatic test_start_ignored;
    src_words = {8'hA5, 8'h3C};
    run_load(0, 0, 8, 0, 0);
    n_checks++;
    if (r_en_cnt !== 16 || r_chain !== 16'h3CA5 || r_done_cyc !== CLR + 18 || r_nres_cnt !== CLR) begin
      n_fail++; $display("FAIL start_in_load: cnt %0d chain %h done %0d clear %0d want 16 3ca5 %0d %0d",
                         r_en_cnt, r_chain, r_done_cyc, r_nres_cnt, CLR + 18, CLR);
    end
    src_words = {8'($urandom), 8'($urandom)};
    run_load(0, 0, -1, 0, 0);
    n_checks++;
    if (r_fab_c1 !== 1'b0 || r_nres_first !== 1 || r_chain !== model_chain(16) || r_done_cyc !== CLR + 18) begin
      n_fail++; $display("FAIL reload_from_done: fab1 %b clr1 %0d chain %h done %0d want 0 1 %h %0d",
                         r_fab_c1, r_nres_first, r_chain, r_done_cyc, model_chain(16), CLR + 18);
    end
  endtask

  task automatic test_nreset;
    src_words = {8'h5A, 8'hC3};
    run_load(1, 0, -1, 5, 2);
    n_checks++;
    if (r_sn !== 7'b0001000) begin
      n_fail++; $display("FAIL async_reset: got %b want 0001000", r_sn);
    end
    @(negedge clock);
    nreset = 1'b1;
    word_valid = '1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (word_ready[1] !== 1'b0 || busy[1] !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_resume[%0d]: ready %b busy %b want 0 0", c, word_ready[1], busy[1]);
      end
    end
    src_words = {8'h5A, 8'hC3};
    run_load(1, 0, -1, 0, 0);
    n_checks++;
    if (r_chain !== model_chain(12) || r_done_cyc !== CLR + 14) begin
      n_fail++; $display("FAIL reset_reload: chain %h done %0d want %h %0d",
                         r_chain, r_done_cyc, model_chain(12), CLR + 14);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_gap();
    test_random();
    test_abort();
    test_start_ignored();
    test_nreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
